// File: rtl/ldpc_cn_serial.sv
// Serial min-sum check-node processor for LDPC decoding.
// Variable-to-check messages arrive one edge at a time. The block tracks the
// two smallest magnitudes, the position of the smallest and the sign of every
// edge. It then replays one check-to-variable message per edge in arrival order.
module ldpc_cn_serial #(
    parameter int W       = 16,
    parameter int DEG_MAX = 8,
    parameter int LOG2DEG = 3,
    parameter int MODE    = 0,
    parameter int OFFSET  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_msg,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_msg,
    output logic [LOG2DEG-1:0] out_idx,
    output logic               out_last,
    output logic               parity,
    output logic               err_overflow
);

    localparam int CW    = LOG2DEG + 1;
    localparam int NSLOT = 1 << LOG2DEG;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] EMIT    = 2'd2;

    localparam logic [W-1:0]  MAX_MAG  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  OFF_W    = W'(OFFSET);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEG_MAX - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      degree_q, degree_d;
    logic [LOG2DEG-1:0] k_q, k_d;
    logic [W-1:0]       min1_q, min1_d;
    logic [W-1:0]       min2_q, min2_d;
    logic [LOG2DEG-1:0] idx1_q, idx1_d;
    logic [NSLOT-1:0]   sign_q, sign_d;
    logic               par_q, par_d;
    logic               err_q, err_d;

    logic               inAcc;
    logic               emitting;
    logic               lastEdge;
    logic [LOG2DEG-1:0] cntIdx;
    logic [W-1:0]       absVal;
    logic [W-1:0]       selMag;
    logic [W-1:0]       adjMag;
    logic               outSign;

    assign emitting = (state_q == EMIT);
    assign in_ready = !emitting;
    assign inAcc    = in_valid && in_ready;
    assign cntIdx   = cnt_q[LOG2DEG-1:0];
    assign lastEdge = ({1'b0, k_q} == (degree_q - CW'(1)));

    // Saturating absolute value so the most negative code never wraps to itself
    always_comb begin
        absVal = in_msg;
        if (in_msg[W-1]) begin
            if (in_msg == MIN_NEG) begin
                absVal = MAX_MAG;
            end else begin
                absVal = -in_msg;
            end
        end
    end

    // Extrinsic magnitude for edge k with the selected min-sum correction applied
    always_comb begin
        selMag  = (k_q == idx1_q) ? min2_q : min1_q;
        adjMag  = selMag;
        outSign = par_q ^ sign_q[k_q];
        case (MODE)
            1: adjMag = (selMag > OFF_W) ? (selMag - OFF_W) : '0;
            2: adjMag = selMag - (selMag >> 2);
            default: adjMag = selMag;
        endcase
    end

    // Output port drive, forced to zero whenever no edge is being presented
    always_comb begin
        out_valid    = emitting;
        out_msg      = '0;
        out_idx      = '0;
        out_last     = 1'b0;
        parity       = 1'b0;
        err_overflow = err_q;
        if (emitting) begin
            out_msg  = outSign ? -adjMag : adjMag;
            out_idx  = k_q;
            out_last = lastEdge;
            parity   = par_q;
        end
    end

    // Next-state logic: gather minima and signs while collecting, step through edges while emitting
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        degree_d = degree_q;
        k_d      = k_q;
        min1_d   = min1_q;
        min2_d   = min2_q;
        idx1_d   = idx1_q;
        sign_d   = sign_q;
        par_d    = par_q;
        err_d    = err_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (inAcc) begin
                    sign_d[cntIdx] = in_msg[W-1];
                    par_d          = par_q ^ in_msg[W-1];
                    if (absVal < min1_q) begin
                        min2_d = min1_q;
                        min1_d = absVal;
                        idx1_d = cntIdx;
                    end else if (absVal < min2_q) begin
                        min2_d = absVal;
                    end
                    cnt_d   = cnt_q + CW'(1);
                    state_d = COLLECT;
                    if (in_last || (cnt_q == LAST_CNT)) begin
                        degree_d = cnt_q + CW'(1);
                        k_d      = '0;
                        state_d  = EMIT;
                        if (!in_last) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (lastEdge) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        degree_d = '0;
                        k_d      = '0;
                        min1_d   = MAX_MAG;
                        min2_d   = MAX_MAG;
                        idx1_d   = '0;
                        sign_d   = '0;
                        par_d    = 1'b0;
                    end else begin
                        k_d = k_q + LOG2DEG'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any check in progress but only reset clears the overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            degree_q <= '0;
            k_q      <= '0;
            min1_q   <= MAX_MAG;
            min2_q   <= MAX_MAG;
            idx1_q   <= '0;
            sign_q   <= '0;
            par_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            degree_q <= degree_d;
            k_q      <= k_d;
            min1_q   <= min1_d;
            min2_q   <= min2_d;
            idx1_q   <= idx1_d;
            sign_q   <= sign_d;
            par_q    <= par_d;
            err_q    <= err_d;
        end
    end

endmodule
